seg7_readback: RTL and testbench

Board-level self-check monitor that reverses the hex-to-segment decoding. It watches four 7-segment digit buses and waits until the combined pattern has been stable for a programmable number of cycles. It then encodes each digit back to a 4-bit nibble and presents the 16-bit value through a valid/ready handshake. It sits beside the counter/display path so a checker, logic analyzer or second counter can compare the value the displays show against the value that was driven.

---
 rtl/seg7_readback.sv | 145 ++++++++++++++
 tb/tb_seg7_readback.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_readback.sv
// seg7_readback: recovers the hex value shown on four active-low 7-segment digit buses.
// Once the combined 28-bit pattern has held for STABLE_CYCLES cycles, each digit is
// decoded back to a nibble. The 16-bit result and per-digit illegal flags are then
// offered on a valid/ready handshake.
//
// Ports:
//   clk    system clock, rising edge
//   aclr   asynchronous reset, active-high
//   hex0   digit 0 (LSD) segments, [0]=a .. [6]=g, active-low
//   hex1   digit 1 segments
//   hex2   digit 2 segments
//   hex3   digit 3 (MSD) segments
//   ready  consumer accepts the presented value while valid is high
//   value  decoded value {hex3,hex2,hex1,hex0} as nibbles
//   valid  value/err are being presented
//   err    err[i] set when digit i showed an illegal pattern
module seg7_readback #(
  parameter int unsigned STABLE_CYCLES = 4  // legal range 1..255
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic [0:6]  hex0,
  input  logic [0:6]  hex1,
  input  logic [0:6]  hex2,
  input  logic [0:6]  hex3,
  input  logic        ready,
  output logic [15:0] value,
  output logic        valid,
  output logic [3:0]  err
);

  localparam logic [0:0] StSettle  = 1'b0;
  localparam logic [0:0] StPresent = 1'b1;

  localparam logic [7:0] CntMax = 8'(STABLE_CYCLES);

  logic [27:0] in_q, in_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [27:0] last_q, last_d;
  logic        first_q, first_d;
  logic [0:0]  state_q, state_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  err_q, err_d;

  logic [27:0] cur;
  logic        stable;
  logic [4:0]  dec0, dec1, dec2, dec3;

  // {err, nibble}; seg is ordered a (bit 6) down to g (bit 0).
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0000001: r = 5'h00;
      7'b1001111: r = 5'h01;
      7'b0010010: r = 5'h02;
      7'b0000110: r = 5'h03;
      7'b1001100: r = 5'h04;
      7'b0100100: r = 5'h05;
      7'b0100000: r = 5'h06;
      7'b0001111: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0000100: r = 5'h09;
      7'b0001000: r = 5'h0a;
      7'b1100000: r = 5'h0b;
      7'b0110001: r = 5'h0c;
      7'b1000010: r = 5'h0d;
      7'b0110000: r = 5'h0e;
      7'b0111000: r = 5'h0f;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  // hexN[0] (segment a) lands on the high bit of each 7-bit field.
  assign cur    = {hex3, hex2, hex1, hex0};
  assign stable = (cnt_q == CntMax);

  assign dec0 = seg_decode(in_q[6:0]);
  assign dec1 = seg_decode(in_q[13:7]);
  assign dec2 = seg_decode(in_q[20:14]);
  assign dec3 = seg_decode(in_q[27:21]);

  always_comb begin
    in_d = cur;
    if (cur != in_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // last/first are only consulted in StSettle, so they can be committed when the value
  // is captured rather than at the transfer; a reset clears them either way.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    err_d   = err_q;
    last_d  = last_q;
    first_d = first_q;
    case (state_q)
      StSettle: begin
        if (stable && (first_q || (in_q != last_q))) begin
          value_d = {dec3[3:0], dec2[3:0], dec1[3:0], dec0[3:0]};
          err_d   = {dec3[4], dec2[4], dec1[4], dec0[4]};
          last_d  = in_q;
          first_d = 1'b0;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (ready) begin
          state_d = StSettle;
        end
      end
      default: state_d = StSettle;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      in_q    <= '1;
      cnt_q   <= 8'd0;
      last_q  <= '1;
      first_q <= 1'b1;
      state_q <= StSettle;
      value_q <= 16'h0000;
      err_q   <= 4'h0;
    end else begin
      in_q    <= in_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      first_q <= first_d;
      state_q <= state_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  assign valid = (state_q == StPresent);
  assign value = value_q;
  assign err   = err_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Self-checking bench for seg7_readback: directed scenarios followed by a random phase,
// all compared every cycle against a behavioural model of the readback rules.
module tb_seg7_readback;

  localparam int unsigned N = 4;

  logic        clk;
  logic        aclr;
  logic [0:6]  hex0, hex1, hex2, hex3;
  logic        ready;
  logic [15:0] value;
  logic        valid;
  logic [3:0]  err;

  seg7_readback #(.STABLE_CYCLES(N)) dut (
    .clk   (clk),
    .aclr  (aclr),
    .hex0  (hex0),
    .hex1  (hex1),
    .hex2  (hex2),
    .hex3  (hex3),
    .ready (ready),
    .value (value),
    .valid (valid),
    .err   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Legal glyphs, a..g left to right, indexed by hex digit.
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic [15:0] seen_val;
  logic [3:0]  seen_err;

  // Model: sampled pattern, how many edges it has stayed put, what is on offer.
  logic [27:0] m_samp;
  int          m_age;
  logic        m_offer;
  logic [27:0] m_offer_pat;
  logic [15:0] m_val;
  logic [3:0]  m_err;
  logic        m_any_accepted;
  logic [27:0] m_accepted;

  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] enc(input logic [15:0] v);
    logic [27:0] p;
    for (int i = 0; i < 4; i++) p[i*7 +: 7] = seg_tab[v[i*4 +: 4]];
    return p;
  endfunction

  task automatic drive(input logic [27:0] p);
    {hex3, hex2, hex1, hex0} = p;
  endtask

  task automatic model_decode(input logic [27:0] p, output logic [15:0] v,
                              output logic [3:0] e);
    for (int d = 0; d < 4; d++) begin
      logic found;
      logic [3:0] nib;
      found = 1'b0;
      nib   = 4'h0;
      for (int k = 0; k < 16; k++) begin
        if (seg_tab[k] == p[d*7 +: 7]) begin
          nib   = 4'(k);
          found = 1'b1;
        end
      end
      v[d*4 +: 4] = nib;
      e[d]        = ~found;
    end
  endtask

  task automatic model_reset();
    m_samp         = '1;
    m_age          = 0;
    m_offer        = 1'b0;
    m_offer_pat    = '1;
    m_val          = 16'h0;
    m_err          = 4'h0;
    m_any_accepted = 1'b0;
    m_accepted     = '1;
  endtask

  // One rising edge of the reference behaviour, using the inputs present at that edge.
  task automatic model_edge();
    logic [27:0] now;
    now = {hex3, hex2, hex1, hex0};
    if (m_offer) begin
      if (ready) begin
        m_accepted     = m_offer_pat;
        m_any_accepted = 1'b1;
        m_offer        = 1'b0;
      end
    end else if (m_age >= N && (!m_any_accepted || m_samp != m_accepted)) begin
      m_offer     = 1'b1;
      m_offer_pat = m_samp;
      model_decode(m_samp, m_val, m_err);
    end
    if (now == m_samp) m_age++;
    else m_age = 0;
    m_samp = now;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", {27'h0, valid}, {27'h0, m_offer});
    chk("value", {12'h0, value}, {12'h0, m_val});
    chk("err", {24'h0, err}, {24'h0, m_err});
    if (valid) begin
      pulses++;
      seen_val = value;
      seen_err = err;
    end
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n;
    n = 0;
    while (!valid && n < limit) begin
      tick();
      n++;
    end
    chk(tag, {27'h0, valid}, 28'h1);
  endtask

  logic [27:0] pool [4];

  initial begin
    aclr  = 1'b1;
    ready = 1'b0;
    drive(enc(16'h4321));
    model_reset();
    #1;
    chk("rst_valid", {27'h0, valid}, 28'h0);
    chk("rst_value", {12'h0, value}, 28'h0);
    chk("rst_err", {24'h0, err}, 28'h0);
    @(posedge clk);
    #1;
    aclr  = 1'b0;
    ready = 1'b1;

    // Basic report of 0x4321 with ready held high.
    pulses = 0;
    repeat (10) tick();
    chk("t1_pulses", 28'(pulses), 28'd1);
    chk("t1_value", {12'h0, seen_val}, 28'h4321);
    chk("t1_err", {24'h0, seen_err}, 28'h0);

    // Glitch filter: hex0 flips every 3 cycles, then 0x00A0 holds.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive(((i / 3) % 2 == 0) ? enc(16'h00A1) : enc(16'h00A0));
      tick();
    end
    chk("t2_toggle_pulses", 28'(pulses), 28'd0);
    drive(enc(16'h00A0));
    repeat (15) tick();
    chk("t2_pulses", 28'(pulses), 28'd1);
    chk("t2_value", {12'h0, seen_val}, 28'h00A0);

    // Hold off: value stays put while inputs move on.
    ready = 1'b0;
    drive(enc(16'hBEEF));
    wait_valid("t3_beef_timeout", 20);
    drive(enc(16'hCAFE));
    repeat (10) tick();
    chk("t3_hold_valid", {27'h0, valid}, 28'h1);
    chk("t3_hold_value", {12'h0, value}, 28'hBEEF);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    chk("t3_next_valid", {27'h0, valid}, 28'h1);
    chk("t3_next_value", {12'h0, value}, 28'hCAFE);
    ready = 1'b1;
    tick();

    // Duplicate suppression.
    drive(enc(16'h1234));
    pulses = 0;
    repeat (60) tick();
    chk("t4_same_pulses", 28'(pulses), 28'd1);
    pulses = 0;
    drive(enc(16'h1235));
    repeat (10) tick();
    chk("t4_1235_pulses", 28'(pulses), 28'd1);
    chk("t4_1235_value", {12'h0, seen_val}, 28'h1235);
    pulses = 0;
    drive(enc(16'h1234));
    repeat (10) tick();
    chk("t4_1234_pulses", 28'(pulses), 28'd1);
    chk("t4_1234_value", {12'h0, seen_val}, 28'h1234);

    // Illegal digits, including blank.
    ready = 1'b0;
    drive({seg_tab[7], 7'b1111111, seg_tab[7], 7'b1111110});
    wait_valid("t5_timeout", 20);
    chk("t5_value", {12'h0, value}, 28'h7070);
    chk("t5_err", {24'h0, err}, 28'h5);
    ready = 1'b1;
    tick();

    // Reset while presenting discards the offer; same pattern reported again after.
    ready = 1'b0;
    drive(enc(16'h5555));
    wait_valid("t6_timeout", 20);
    chk("t6_pre_value", {12'h0, value}, 28'h5555);
    aclr = 1'b1;
    #1;
    chk("t6_rst_valid", {27'h0, valid}, 28'h0);
    chk("t6_rst_value", {12'h0, value}, 28'h0);
    model_reset();
    @(posedge clk);
    #1;
    aclr   = 1'b0;
    ready  = 1'b1;
    pulses = 0;
    repeat (10) tick();
    chk("t6_pulses", 28'(pulses), 28'd1);
    chk("t6_value", {12'h0, seen_val}, 28'h5555);

    // Random phase: a small pool of patterns (some illegal) with random holds and ready.
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(0, 4) == 0) pool[i][d*7 +: 7] = 7'($urandom);
        else pool[i][d*7 +: 7] = seg_tab[$urandom_range(0, 15)];
      end
    end
    for (int r = 0; r < 80; r++) begin
      int hold;
      drive(pool[$urandom_range(0, 3)]);
      hold = $urandom_range(1, 9);
      for (int h = 0; h < hold; h++) begin
        ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
